// File: rtl/reg_bank_mp.sv
// rtl/reg_bank_mp.sv - two-write, two-read register bank with write-first bypass and sequential clear sweep
module reg_bank_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              we_0,
   input  logic              we_1,
   input  logic [ADDR_W-1:0] waddr_0,
   input  logic [ADDR_W-1:0] waddr_1,
   input  logic [DATA_W-1:0] wdata_0,
   input  logic [DATA_W-1:0] wdata_1,
   input  logic              clear_req,
   output logic              busy
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state;
   logic [ADDR_W:0]   ptr;
   logic [ADDR_W:0]   ptr_inc;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_0;
   logic              wr_1;
   logic [DATA_W-1:0] next_a;
   logic [DATA_W-1:0] next_b;

   // Writes are only accepted in IDLE; entry 0 is read-only zero when ZERO_REG is set.
   assign wr_0    = we_0 && (state == IDLE) && !(ZERO_REG != 0 && waddr_0 == '0);
   assign wr_1    = we_1 && (state == IDLE) && !(ZERO_REG != 0 && waddr_1 == '0);
   assign ptr_inc = ptr + 1'b1;

   // Write-first bypass, port 0 taking priority over port 1 on an address collision.
   always_comb begin
      next_a = mem[raddr_a];
      if (ZERO_REG != 0 && raddr_a == '0)  next_a = '0;
      else if (wr_0 && waddr_0 == raddr_a) next_a = wdata_0;
      else if (wr_1 && waddr_1 == raddr_a) next_a = wdata_1;

      next_b = mem[raddr_b];
      if (ZERO_REG != 0 && raddr_b == '0)  next_b = '0;
      else if (wr_0 && waddr_0 == raddr_b) next_b = wdata_0;
      else if (wr_1 && waddr_1 == raddr_b) next_b = wdata_1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         ptr     <= '0;
         rdata_a <= '0;
         rdata_b <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (state == IDLE) begin
         if (wr_1) mem[waddr_1] <= wdata_1;
         if (wr_0) mem[waddr_0] <= wdata_0;
         if (clear_req) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            ptr     <= '0;
            rdata_a <= '0;
            rdata_b <= '0;
         end else begin
            rdata_a <= next_a;
            rdata_b <= next_b;
         end
      end else begin
         // The extra pointer bit flags the pass over the last entry without wrap ambiguity.
         mem[ptr[ADDR_W-1:0]] <= '0;
         ptr     <= ptr_inc;
         rdata_a <= '0;
         rdata_b <= '0;
         if (ptr_inc[ADDR_W]) begin
            state <= IDLE;
            busy  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_reg_bank_mp.sv
// tb/tb_reg_bank_mp.sv - self-checking bench for reg_bank_mp with table vectors, random traffic and clear-sweep sequences
module tb_reg_bank_mp;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  raddr_a = '0, raddr_b = '0, waddr_0 = '0, waddr_1 = '0;
   logic [31:0] rdata_a, rdata_b, wdata_0 = '0, wdata_1 = '0;
   logic        we_0 = 1'b0, we_1 = 1'b0, clear_req = 1'b0, busy;

   logic [2:0]  s_raddr_a = '0, s_raddr_b = '0, s_waddr_0 = '0, s_waddr_1 = '0;
   logic [15:0] s_rdata_a, s_rdata_b, s_wdata_0 = '0, s_wdata_1 = '0;
   logic        s_we_0 = 1'b0, s_we_1 = 1'b0, s_clear_req = 1'b0, s_busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m [32];
   int          clr_left;
   logic [31:0] exp_a, exp_b;

   always #5 clock = ~clock;

   reg_bank_mp dut (
      .clock(clock), .reset(reset),
      .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
      .we_0(we_0), .we_1(we_1), .waddr_0(waddr_0), .waddr_1(waddr_1),
      .wdata_0(wdata_0), .wdata_1(wdata_1), .clear_req(clear_req), .busy(busy)
   );

   reg_bank_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut_s (
      .clock(clock), .reset(reset),
      .raddr_a(s_raddr_a), .raddr_b(s_raddr_b), .rdata_a(s_rdata_a), .rdata_b(s_rdata_b),
      .we_0(s_we_0), .we_1(s_we_1), .waddr_0(s_waddr_0), .waddr_1(s_waddr_1),
      .wdata_0(s_wdata_0), .wdata_1(s_wdata_1), .clear_req(s_clear_req), .busy(s_busy)
   );

   typedef struct {
      logic        w0;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic        w1;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] ea;
      logic [31:0] eb;
   } vec_t;

   vec_t vt [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a, input logic w0, input logic [4:0] a0,
                                              input logic [31:0] d0, input logic w1, input logic [4:0] a1,
                                              input logic [31:0] d1);
      if (a == 5'd0) return 32'h0;
      if (w0 && a0 == a) return d0;
      if (w1 && a1 == a) return d1;
      return mem_m[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
      clr_left = 0;
   endtask

   // One clock: drive inputs, advance the reference model, compare just after the edge.
   task automatic step(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] ra, input logic [4:0] rb, input logic clr);
      we_0 = w0; waddr_0 = a0; wdata_0 = d0;
      we_1 = w1; waddr_1 = a1; wdata_1 = d1;
      raddr_a = ra; raddr_b = rb; clear_req = clr;
      if (clr_left > 0) begin
         mem_m[32 - clr_left] = 32'h0;
         clr_left--;
         exp_a = 32'h0;
         exp_b = 32'h0;
      end else begin
         exp_a = model_read(ra, w0, a0, d0, w1, a1, d1);
         exp_b = model_read(rb, w0, a0, d0, w1, a1, d1);
         if (w1 && a1 != 5'd0) mem_m[a1] = d1;
         if (w0 && a0 != 5'd0) mem_m[a0] = d0;
         if (clr) begin
            clr_left = 32;
            exp_a = 32'h0;
            exp_b = 32'h0;
         end
      end
      @(posedge clock);
      #1;
      chk("rdata_a", rdata_a, exp_a);
      chk("rdata_b", rdata_b, exp_b);
      chk("busy", {31'b0, busy}, (clr_left > 0) ? 32'd1 : 32'd0);
   endtask

   task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, ra, rb, 1'b0);
   endtask

   initial begin
      int n;
      model_reset();
      vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
      vt[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
      vt[2] = '{1'b1, 5'd3, 32'h11,       1'b1, 5'd3, 32'h22,       5'd0, 5'd3, 32'h0,        32'h11};
      vt[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 32'h11,       32'h11};
      vt[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 32'h0,        32'h0};
      vt[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0};
      vt[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h12345678, 5'd7, 5'd6, 32'h12345678, 32'h0};
      vt[7] = '{1'b1, 5'd6, 32'hCAFE0000, 1'b1, 5'd9, 32'h99,       5'd9, 5'd6, 32'h99,       32'hCAFE0000};
      vt[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 5'd7, 32'h99,       32'h12345678};

      #3;
      chk("reset_rdata_a", rdata_a, 32'h0);
      chk("reset_rdata_b", rdata_b, 32'h0);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_small_rdata", {16'h0, s_rdata_a}, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         step(vt[i].w0, vt[i].a0, vt[i].d0, vt[i].w1, vt[i].a1, vt[i].d1, vt[i].ra, vt[i].rb, 1'b0);
         chk($sformatf("vec%0d_a", i), rdata_a, vt[i].ea);
         chk($sformatf("vec%0d_b", i), rdata_b, vt[i].eb);
      end

      for (int i = 0; i < 400; i++) begin
         logic [4:0] a0, a1;
         a0 = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         a1 = ($urandom % 4 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         step(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom,
              5'($urandom_range(0, 9)), 5'($urandom), ($urandom % 50) == 0);
      end
      while (clr_left > 0) idle(5'd1, 5'd2);

      // Fill with index values, final write coincides with the clear request.
      for (int i = 0; i < 31; i++) step(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'h0, 5'(i), 5'd0, 1'b0);
      step(1'b1, 5'd31, 32'd31, 1'b0, 5'd0, 32'h0, 5'd30, 5'd31, 1'b1);
      n = busy ? 1 : 0;
      for (int g = 0; g < 100 && busy; g++) begin
         step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom,
              5'($urandom), 5'($urandom), g == 5);
         if (busy) n++;
      end
      chk("clear_busy_cycles", 32'(n), 32'd32);
      for (int i = 0; i < 32; i++) begin
         idle(5'(i), 5'(31 - i));
         chk("post_clear_a", rdata_a, 32'h0);
      end

      // Reset lands in the middle of a sweep.
      for (int i = 1; i < 8; i++) step(1'b1, 5'(i), 32'hA000 + 32'(i), 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0);
      idle(5'd1, 5'd2);
      chk("pre_sweep_read", rdata_a, 32'hA001);
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1);
      for (int i = 0; i < 10; i++) idle(5'd3, 5'd4);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_rdata_a", rdata_a, 32'h0);
      chk("abort_rdata_b", rdata_b, 32'h0);
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) idle(5'(i), 5'(i + 8));
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
      idle(5'd5, 5'd6);
      chk("post_reset_write", rdata_a, 32'hDEADBEEF);

      // Narrow instance without a hardwired zero entry.
      s_we_0 = 1'b1; s_waddr_0 = 3'd0; s_wdata_0 = 16'hABCD; s_raddr_a = 3'd0; s_raddr_b = 3'd0;
      idle(5'd0, 5'd0);
      chk("small_bypass", {16'h0, s_rdata_a}, 32'h0000ABCD);
      s_we_0 = 1'b0;
      idle(5'd0, 5'd0);
      chk("small_read", {16'h0, s_rdata_b}, 32'h0000ABCD);
      s_clear_req = 1'b1;
      idle(5'd0, 5'd0);
      s_clear_req = 1'b0;
      n = s_busy ? 1 : 0;
      for (int g = 0; g < 50 && s_busy; g++) begin
         idle(5'd0, 5'd0);
         if (s_busy) n++;
      end
      chk("small_busy_cycles", 32'(n), 32'd8);
      idle(5'd0, 5'd0);
      chk("small_post_clear", {16'h0, s_rdata_a}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
